// File: rtl/digital_clock_pkg.sv
// Types and constants shared by the alarm path of the digital clock.
// The status-digit encoding lives here so every consumer uses the same segments.
package digital_clock_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RINGING,
    SNOOZE,
    DONE
  } alarm_state_e;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_A     = 7'b000_1000;
  localparam logic [6:0] SEG_S     = 7'b001_0010;
  localparam logic [6:0] SEG_BLANK = 7'b111_1111;

  function automatic logic [6:0] status_seg(alarm_state_e st, logic beep);
    logic [6:0] seg;
    seg = SEG_BLANK;
    if (st == RINGING && beep) begin
      seg = SEG_A;
    end else if (st == SNOOZE) begin
      seg = SEG_S;
    end
    return seg;
  endfunction

endpackage

// File: rtl/sec_timer.sv
// Loadable seconds down-counter; flags the tick that will take it from 1 to 0.
// It stops at zero rather than wrapping.
module sec_timer #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         zero_next
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (tick && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero_next = tick & (count_q == W'(1));

endmodule

// File: rtl/alarm_ringer.sv
// Alarm annunciation: sequences ring / snooze / done from the hh:mm match level,
// drives a 1 Hz beeping buzzer and an active-low status digit. All outputs are registered.
module alarm_ringer
  import digital_clock_pkg::*;
#(
  parameter int  RING_SECS   = 60,
  parameter int  SNOOZE_SECS = 300,
  parameter int  MAX_SNOOZE  = 3,
  localparam int CNT_W       = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_1hz,
  input  logic             alarm_match,
  input  logic             alarm_enable,
  input  logic             ack,
  input  logic             snooze,
  output logic             ringing,
  output logic             snoozing,
  output logic             buzzer,
  output logic [CNT_W-1:0] snooze_cnt,
  output logic [6:0]       alarm_led
);

  localparam int TMR_MAX = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] RING_LD   = TMR_W'(RING_SECS);
  localparam logic [TMR_W-1:0] SNOOZE_LD = TMR_W'(SNOOZE_SECS);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_SNOOZE);

  alarm_state_e     state_q, state_d;
  logic             match_q;
  logic             buzzer_q, buzzer_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ringing_q, snoozing_q;
  logic [6:0]       led_q;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_zero_next;
  logic             match_edge;

  // match_q resets high so a minute already matching at release is not an edge
  assign match_edge = alarm_match & ~match_q;

  sec_timer #(.W(TMR_W)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (tmr_load),
    .load_val  (tmr_val),
    .tick      (tick_1hz),
    .zero_next (tmr_zero_next)
  );

  always_comb begin
    state_d  = state_q;
    buzzer_d = buzzer_q;
    cnt_d    = cnt_q;
    tmr_load = 1'b0;
    tmr_val  = RING_LD;
    case (state_q)
      IDLE: begin
        if (match_edge && alarm_enable) begin
          state_d  = RINGING;
          tmr_load = 1'b1;
          buzzer_d = 1'b1;
        end
      end
      RINGING: begin
        if (!alarm_enable) begin
          state_d  = IDLE;
          cnt_d    = '0;
          buzzer_d = 1'b0;
        end else if (ack) begin
          state_d  = DONE;
          cnt_d    = '0;
          buzzer_d = 1'b0;
        end else if (snooze && (cnt_q < CNT_MAX)) begin
          state_d  = SNOOZE;
          tmr_load = 1'b1;
          tmr_val  = SNOOZE_LD;
          cnt_d    = cnt_q + 1'b1;
          buzzer_d = 1'b0;
        end else if (tmr_zero_next) begin
          state_d  = DONE;
          cnt_d    = '0;
          buzzer_d = 1'b0;
        end else if (tick_1hz) begin
          buzzer_d = ~buzzer_q;
        end
      end
      SNOOZE: begin
        if (!alarm_enable) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (ack) begin
          state_d = DONE;
          cnt_d   = '0;
        end else if (tmr_zero_next) begin
          state_d  = RINGING;
          tmr_load = 1'b1;
          buzzer_d = 1'b1;
        end
      end
      DONE: begin
        buzzer_d = 1'b0;
        cnt_d    = '0;
        // Holding here while the minute still matches prevents a re-trigger
        if (!alarm_match) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d  = IDLE;
        buzzer_d = 1'b0;
        cnt_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      match_q    <= 1'b1;
      buzzer_q   <= 1'b0;
      cnt_q      <= '0;
      ringing_q  <= 1'b0;
      snoozing_q <= 1'b0;
      led_q      <= SEG_BLANK;
    end else begin
      state_q    <= state_d;
      match_q    <= alarm_match;
      buzzer_q   <= buzzer_d;
      cnt_q      <= cnt_d;
      ringing_q  <= (state_d == RINGING);
      snoozing_q <= (state_d == SNOOZE);
      led_q      <= status_seg(state_d, buzzer_d);
    end
  end

  assign ringing    = ringing_q;
  assign snoozing   = snoozing_q;
  assign buzzer     = buzzer_q;
  assign snooze_cnt = cnt_q;
  assign alarm_led  = led_q;

endmodule

// File: tb/tb_alarm_ringer.sv
// Scoreboard bench for alarm_ringer: a behavioural model predicts each cycle's outputs,
// a monitor compares them after every clock edge.
module tb_alarm_ringer;

  localparam int RS = 3;
  localparam int SS = 2;
  localparam int MS = 1;
  localparam int CW = 1;
  localparam logic [6:0] LED_A     = 7'b000_1000;
  localparam logic [6:0] LED_S     = 7'b001_0010;
  localparam logic [6:0] LED_BLANK = 7'b111_1111;

  logic          clk = 1'b0;
  logic          reset, tick_1hz, alarm_match, alarm_enable, ack, snooze;
  logic          ringing, snoozing, buzzer;
  logic [CW-1:0] snooze_cnt;
  logic [6:0]    alarm_led;

  always #5 clk = ~clk;

  alarm_ringer #(.RING_SECS(RS), .SNOOZE_SECS(SS), .MAX_SNOOZE(MS)) dut (
    .clk          (clk),
    .reset        (reset),
    .tick_1hz     (tick_1hz),
    .alarm_match  (alarm_match),
    .alarm_enable (alarm_enable),
    .ack          (ack),
    .snooze       (snooze),
    .ringing      (ringing),
    .snoozing     (snoozing),
    .buzzer       (buzzer),
    .snooze_cnt   (snooze_cnt),
    .alarm_led    (alarm_led)
  );

  typedef struct packed {
    logic          ring;
    logic          snz;
    logic          buz;
    logic [CW-1:0] cnt;
    logic [6:0]    led;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   tick_div = 0;

  // Reference model: which phase of the alarm event we are in, seconds left, snoozes used
  bit m_ringing, m_snoozing, m_done, m_beep, m_prev_match;
  int m_left, m_used;

  task automatic model_step();
    bit rise;
    if (reset) begin
      m_ringing = 0; m_snoozing = 0; m_done = 0; m_beep = 0;
      m_used = 0; m_left = 0; m_prev_match = 1;
      return;
    end
    rise = alarm_match && !m_prev_match;
    m_prev_match = alarm_match;
    if (m_ringing) begin
      if (!alarm_enable) begin
        m_ringing = 0; m_used = 0; m_beep = 0;
      end else if (ack) begin
        m_ringing = 0; m_done = 1; m_used = 0; m_beep = 0;
      end else if (snooze && m_used < MS) begin
        m_ringing = 0; m_snoozing = 1; m_left = SS; m_used++; m_beep = 0;
      end else if (tick_1hz) begin
        if (m_left == 1) begin
          m_ringing = 0; m_done = 1; m_used = 0; m_beep = 0;
        end else begin
          m_left--; m_beep = !m_beep;
        end
      end
    end else if (m_snoozing) begin
      if (!alarm_enable) begin
        m_snoozing = 0; m_used = 0;
      end else if (ack) begin
        m_snoozing = 0; m_done = 1; m_used = 0;
      end else if (tick_1hz) begin
        if (m_left == 1) begin
          m_snoozing = 0; m_ringing = 1; m_left = RS; m_beep = 1;
        end else begin
          m_left--;
        end
      end
    end else if (m_done) begin
      if (!alarm_match) m_done = 0;
    end else if (rise && alarm_enable) begin
      m_ringing = 1; m_left = RS; m_beep = 1;
    end
  endtask

  function automatic exp_t exp_now();
    exp_t e;
    e.ring = m_ringing;
    e.snz  = m_snoozing;
    e.buz  = m_beep;
    e.cnt  = CW'(m_used);
    e.led  = m_ringing ? (m_beep ? LED_A : LED_BLANK) : (m_snoozing ? LED_S : LED_BLANK);
    return e;
  endfunction

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      if (errors <= 25)
        $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endfunction

  // One clock of stimulus: tick every 10 clocks, predict, push, advance; pulses self-clear
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1hz = (tick_div == 9);
      tick_div = (tick_div == 9) ? 0 : tick_div + 1;
      model_step();
      expq.push_back(exp_now());
      @(posedge clk);
      #1;
      ack = 1'b0;
      snooze = 1'b0;
    end
  endtask

  task automatic to_tick_cycle();
    while (tick_div != 9) step(1);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("ringing",    32'(ringing),    32'(e.ring));
        chk("snoozing",   32'(snoozing),   32'(e.snz));
        chk("buzzer",     32'(buzzer),     32'(e.buz));
        chk("snooze_cnt", 32'(snooze_cnt), 32'(e.cnt));
        chk("alarm_led",  32'(alarm_led),  32'(e.led));
      end
    end
  end

  initial begin
    int len;
    reset = 1; tick_1hz = 0; alarm_match = 0; alarm_enable = 1; ack = 0; snooze = 0;
    step(3);
    reset = 0;
    step(2);
    // Plain ring to timeout
    alarm_match = 1; step(45);
    alarm_match = 0; step(3);
    // Snooze, re-ring, second snooze ignored
    alarm_match = 1; step(2);
    snooze = 1; step(1);
    step(25);
    snooze = 1; step(1);
    step(40);
    alarm_match = 0; step(3);
    // ack together with snooze, then hold in DONE
    alarm_match = 1; step(3);
    ack = 1; snooze = 1; step(1);
    step(30);
    alarm_match = 0; step(2);
    // Disable during snooze
    alarm_match = 1; step(2);
    snooze = 1; step(1);
    step(3);
    alarm_enable = 0; step(3);
    alarm_enable = 1; alarm_match = 0; step(2);
    // Reset mid-ring with match held, then a fresh rise
    alarm_match = 1; step(5);
    reset = 1; step(2);
    reset = 0; step(30);
    alarm_match = 0; step(3);
    alarm_match = 1; step(10);
    ack = 1; step(1);
    alarm_match = 0; step(2);
    // Snooze on the final tick
    alarm_match = 1; step(1);
    repeat (2) begin
      to_tick_cycle(); step(1);
    end
    to_tick_cycle();
    snooze = 1; step(1);
    step(3);
    alarm_enable = 0; step(2);
    alarm_enable = 1; alarm_match = 0; step(2);
    // Randomized minutes
    for (int k = 0; k < 60; k++) begin
      alarm_match = 1;
      alarm_enable = ($urandom_range(0, 9) != 0);
      len = $urandom_range(20, 120);
      for (int c = 0; c < len; c++) begin
        ack    = ($urandom_range(0, 39) == 0);
        snooze = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 99) == 0) alarm_enable = ~alarm_enable;
        reset  = ($urandom_range(0, 199) == 0);
        step(1);
      end
      alarm_match = 0;
      reset = 0;
      alarm_enable = 1;
      step($urandom_range(1, 30));
    end
    repeat (3) @(posedge clk);
    #3;
    chk("drain", 32'(expq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
